sample_sched: RTL

SAMPLE_SCHED -- requirements
Module: sample_sched

---
 rtl/sample_sched.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sample_sched.sv
// Sample scheduler: buffers upstream samples in a small FIFO and releases one
// per RATIO-cycle period to an interpolator as a prev/cur pair with load/step timing.
module sample_sched #(
    parameter int WIDTH      = 20,
    parameter int RATIO      = 50,
    parameter int LOAD_PHASE = 24,
    parameter int DEPTH      = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         smp_prev,
    output logic [WIDTH-1:0]         smp_cur,
    output logic                     smp_strobe,
    output logic                     load_o,
    output logic                     step_en,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun
);

    localparam int PW  = $clog2(DEPTH);
    localparam int PHW = $clog2(RATIO + 1);

    localparam logic [PW:0]    LVL_FULL   = (PW + 1)'(DEPTH);
    localparam logic [PW:0]    LVL_PRIME  = (PW + 1)'(2);
    localparam logic [PW:0]    LVL_ONE    = (PW + 1)'(1);
    localparam logic [PW-1:0]  PTR_ONE    = PW'(1);
    localparam logic [PHW-1:0] PH_LAST    = PHW'(RATIO - 1);
    localparam logic [PHW-1:0] PH_LOAD    = PHW'(LOAD_PHASE);
    localparam logic [PHW-1:0] PH_ONE     = PHW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [PHW-1:0]   r_phase;
    logic [PHW-1:0]   w_nextPhase;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [PW:0]      r_count;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_cur;
    logic             r_strobe;
    logic             r_load;
    logic             r_step;
    logic             r_underrun;

    logic             w_push;
    logic             w_pop;
    logic             w_loadCur;
    logic             w_shift;
    logic             w_setUnderrun;
    logic             w_clrUnderrun;
    logic             w_boundary;
    logic             w_empty;
    logic             w_nextActive;
    logic [WIDTH-1:0] w_head;

    assign in_ready   = (r_count < LVL_FULL);
    assign fifo_level = r_count;
    assign w_push     = in_valid && in_ready;
    assign w_head     = r_mem[r_rdPtr];
    assign w_empty    = (r_count == '0);
    assign w_boundary = (r_phase == PH_LAST);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LVL_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - LVL_ONE;
            end
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextPhase   = r_phase;
        w_pop         = 1'b0;
        w_loadCur     = 1'b0;
        w_shift       = 1'b0;
        w_setUnderrun = 1'b0;
        w_clrUnderrun = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextPhase = '0;
                if (enable) begin
                    w_nextState   = PRIME;
                    w_clrUnderrun = 1'b1;
                end
            end
            PRIME: begin
                w_nextPhase = '0;
                if (!enable) begin
                    w_nextState = IDLE;
                end else if (r_count >= LVL_PRIME) begin
                    w_pop       = 1'b1;
                    w_loadCur   = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN, DRAIN: begin
                w_nextPhase = w_boundary ? '0 : r_phase + PH_ONE;
                if (r_state == RUN && !enable) begin
                    w_nextState = DRAIN;
                end
                // An empty FIFO at the boundary repeats the current sample.
                if (w_boundary) begin
                    w_shift = 1'b1;
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_loadCur = 1'b1;
                    end else begin
                        w_setUnderrun = 1'b1;
                    end
                    if (r_state == DRAIN) begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextPhase = '0;
            end
        endcase
    end

    assign w_nextActive = (w_nextState == RUN) || (w_nextState == DRAIN);

    // load/step are computed from the next state/phase so the registered
    // outputs line up with the state and phase they describe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_prev     <= '0;
            r_cur      <= '0;
            r_strobe   <= 1'b0;
            r_load     <= 1'b0;
            r_step     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_phase  <= w_nextPhase;
            r_strobe <= w_loadCur || w_shift;
            r_load   <= w_nextActive && (w_nextPhase == PH_LOAD);
            r_step   <= w_nextActive && (w_nextPhase != PH_LOAD);
            if (w_shift) begin
                r_prev <= r_cur;
            end
            if (w_loadCur) begin
                r_cur <= w_head;
            end
            if (w_clrUnderrun) begin
                r_underrun <= 1'b0;
            end else if (w_setUnderrun) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign state_o    = r_state;
    assign smp_prev   = r_prev;
    assign smp_cur    = r_cur;
    assign smp_strobe = r_strobe;
    assign load_o     = r_load;
    assign step_en    = r_step;
    assign underrun   = r_underrun;

endmodule
